// File: rtl/stream_mux_rr_pkg.sv
// Common definitions for the round-robin stream mux.
package stream_mux_rr_pkg;
  `include "stream_mux_defs.vh"
endpackage

// File: rtl/stream_mux_defs.vh
`ifndef STREAM_MUX_DEFS_VH
`define STREAM_MUX_DEFS_VH
// Arbitration mode encodings and the width helper shared by the mux and its arbiter.
localparam logic MODE_FIXED = 1'b0;
localparam logic MODE_RR    = 1'b1;

function automatic int clog2(input int value);
  int r;
  r = 0;
  for (int i = 0; i < 31; i++) begin
    if ((1 << i) < value) r = i + 1;
  end
  return r;
endfunction
`endif

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational N-way arbiter: fixed priority from index 0, or round-robin from ptr.
// Zero latency; grants only among requesting channels.
module rr_arbiter
  import stream_mux_rr_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CHAN_W   = 2
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CHAN_W-1:0]   ptr,
  input  logic                mode,
  output logic [CHANNELS-1:0] gnt,
  output logic [CHAN_W-1:0]   gnt_idx,
  output logic                any_gnt
);

  always_comb begin
    int start;
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = 0;
    start   = (mode == MODE_RR) ? int'(ptr) : 0;
    // Rotated scan: first requester at or after start, wrapping past the top channel.
    for (int k = 0; k < CHANNELS; k++) begin
      idx = start + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!any_gnt && req[idx]) begin
        any_gnt  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = CHAN_W'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with fixed-priority or round-robin arbitration.
// One-cycle registered output; in_ready drops to zero while the held word is stalled.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int CHAN_W   = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [CHAN_W-1:0]         out_chan,
  input  logic                      out_ready
);

  logic [CHAN_W-1:0]   rr_ptr;
  logic [CHAN_W-1:0]   gnt_idx;
  logic [CHANNELS-1:0] gnt;
  logic                any_gnt;
  logic                load_en;
  logic                xfer;

  rr_arbiter #(
    .CHANNELS(CHANNELS),
    .CHAN_W  (CHAN_W)
  ) u_arb (
    .req    (in_valid),
    .ptr    (rr_ptr),
    .mode   (mode),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .any_gnt(any_gnt)
  );

  assign load_en  = !out_valid || out_ready;
  assign xfer     = rst_n && load_en && any_gnt;
  assign in_ready = xfer ? gnt : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(gnt_idx)*WIDTH +: WIDTH];
      out_chan  <= gnt_idx;
      // Pointer moves in both modes so a later switch to round-robin starts fairly.
      rr_ptr    <= (gnt_idx == CHAN_W'(CHANNELS-1)) ? '0 : gnt_idx + CHAN_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed table plus randomized run against a queue-free behavioural model of the mux.
module tb_stream_mux_rr;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mode;
  logic [N-1:0]  in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_chan;
  logic          out_ready;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(W), .CHANNELS(N)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_chan(out_chan), .out_ready(out_ready)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        md;
    logic [3:0]  vld;
    logic [31:0] dat;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_v;
    logic [7:0]  e_d;
    logic [1:0]  e_c;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic md, logic [3:0] vld, logic [31:0] dat,
                              logic ordy, logic [3:0] e_rdy, logic e_v, logic [7:0] e_d,
                              logic [1:0] e_c);
    vec_t v;
    v.rst = rst; v.md = md; v.vld = vld; v.dat = dat; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_v = e_v; v.e_d = e_d; v.e_c = e_c;
    return v;
  endfunction

  // Behavioural model state
  logic       m_v;
  logic [7:0] m_d;
  int         m_c;
  int         m_ptr;

  logic [N-1:0] pv;
  logic [7:0]   pd [N];

  initial begin
    //                rst md  vld      data           ordy e_rdy    v  d      c
    tbl.push_back(mk(0, 0, 4'b1111, 32'h44332211, 1, 4'b0000, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 4'b1111, 32'h44332211, 1, 4'b0000, 0, 8'h00, 0));
    tbl.push_back(mk(1, 0, 4'b0100, 32'h00A50000, 0, 4'b0100, 1, 8'hA5, 2));
    tbl.push_back(mk(1, 0, 4'b1010, 32'h33001100, 1, 4'b0010, 1, 8'h11, 1));
    tbl.push_back(mk(1, 0, 4'b1010, 32'h33001100, 1, 4'b0010, 1, 8'h11, 1));
    tbl.push_back(mk(1, 0, 4'b1010, 32'h33001100, 1, 4'b0010, 1, 8'h11, 1));
    tbl.push_back(mk(1, 0, 4'b1000, 32'h33000000, 1, 4'b1000, 1, 8'h33, 3));
    tbl.push_back(mk(1, 1, 4'b1111, 32'h13121110, 0, 4'b0000, 1, 8'h33, 3));
    tbl.push_back(mk(1, 1, 4'b1111, 32'h13121110, 0, 4'b0000, 1, 8'h33, 3));
    tbl.push_back(mk(1, 1, 4'b1111, 32'h13121110, 0, 4'b0000, 1, 8'h33, 3));
    tbl.push_back(mk(1, 1, 4'b1111, 32'h13121110, 1, 4'b0001, 1, 8'h10, 0));
    tbl.push_back(mk(1, 1, 4'b1111, 32'h13121110, 1, 4'b0010, 1, 8'h11, 1));
    tbl.push_back(mk(1, 1, 4'b1111, 32'h13121110, 1, 4'b0100, 1, 8'h12, 2));
    tbl.push_back(mk(1, 1, 4'b1111, 32'h13121110, 1, 4'b1000, 1, 8'h13, 3));
    tbl.push_back(mk(1, 1, 4'b1111, 32'h13121110, 1, 4'b0001, 1, 8'h10, 0));
    tbl.push_back(mk(1, 1, 4'b0100, 32'h00220000, 1, 4'b0100, 1, 8'h22, 2));
    tbl.push_back(mk(1, 1, 4'b0101, 32'h00420040, 1, 4'b0001, 1, 8'h40, 0));
    tbl.push_back(mk(1, 1, 4'b0101, 32'h00420040, 1, 4'b0100, 1, 8'h42, 2));
    tbl.push_back(mk(1, 1, 4'b0000, 32'h00000000, 1, 4'b0000, 0, 8'h42, 2));
    tbl.push_back(mk(1, 1, 4'b0010, 32'h00007700, 0, 4'b0010, 1, 8'h77, 1));
    tbl.push_back(mk(0, 1, 4'b0000, 32'h00000000, 0, 4'b0000, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 4'b1111, 32'h13121110, 1, 4'b0001, 1, 8'h10, 0));
    tbl.push_back(mk(1, 0, 4'b1110, 32'h13121110, 1, 4'b0010, 1, 8'h11, 1));
    tbl.push_back(mk(1, 1, 4'b1111, 32'h13121110, 1, 4'b0100, 1, 8'h12, 2));

    rst_n = 1'b0; mode = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b1;
    #1;
    foreach (tbl[i]) begin
      rst_n     = tbl[i].rst;
      mode      = tbl[i].md;
      in_valid  = tbl[i].vld;
      in_data   = tbl[i].dat;
      out_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_v));
      chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(tbl[i].e_d));
      chk($sformatf("vec%0d out_chan", i), 32'(out_chan), 32'(tbl[i].e_c));
    end

    // Randomized run: producers hold each word until it is accepted.
    m_v = 1'b0; m_d = '0; m_c = 0; m_ptr = 0;
    pv = '0;
    for (int i = 0; i < N; i++) pd[i] = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic [N-1:0] er;
      int g;
      logic rs, md, ordy;
      logic [N-1:0] iv;
      logic [N*W-1:0] idat;

      rs   = !(cyc < 2 || (cyc % 250) == 249);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      md   = mode;
      ordy = ($urandom_range(0, 3) != 0);
      iv   = pv;
      for (int i = 0; i < N; i++) idat[i*W +: W] = pd[i];
      rst_n = rs; in_valid = iv; in_data = idat; out_ready = ordy;

      @(negedge clk);
      er = '0; g = -1;
      if (rs && (!m_v || ordy)) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = ((md ? m_ptr : 0) + k) % N;
          if (g < 0 && iv[c]) g = c;
        end
        if (g >= 0) er[g] = 1'b1;
      end
      chk("rnd in_ready", 32'(in_ready), 32'(er));
      @(posedge clk);
      #1;
      if (!rs) begin
        m_v = 1'b0; m_d = '0; m_c = 0; m_ptr = 0;
      end else if (g >= 0) begin
        m_v = 1'b1; m_d = idat[g*W +: W]; m_c = g; m_ptr = (g + 1) % N;
        pv[g] = 1'b0;
      end else if (ordy) begin
        m_v = 1'b0;
      end
      chk("rnd out_valid", 32'(out_valid), 32'(m_v));
      chk("rnd out_data", 32'(out_data), 32'(m_d));
      chk("rnd out_chan", 32'(out_chan), 32'(m_c));
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1'b1;
          pd[i] = 8'($urandom);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
